soc_wb2sram: RTL and testbench
==============================

Name: soc_wb2sram

Overview:
- Wishbone B3 slave bridge that converts bus cycles into the native single-port SRAM protocol: ce/we/oe, word address, byte selects, and registered read data with 1-cycle latency.
- Sits directly upstream of the tile's single-port SRAM.
- Zero-wait-state writes; one wait state on the first beat of a read.
- Incrementing/wrapping read bursts sustain 1 beat/cycle via predictive next-address issue.

Parameters:
- AW, 32, byte address width.
- DW, 32, data width (8/16/32).
- SW, derived (DW/8), number of byte selects; localparam.
- WORD_AW, AW-(SW>>1), SRAM word address width.
- MEM_SIZE_BYTE, 'hx, memory size in bytes. MEM_SIZE_WORDS = MEM_SIZE_BYTE/SW is a localparam.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- wb_adr_i  input  AW  byte address
- wb_dat_i  input  DW  write data
- wb_sel_i  input  SW  byte selects
- wb_we_i  input  1  write enable
- wb_cyc_i  input  1  cycle valid
- wb_stb_i  input  1  strobe
- wb_cti_i  input  3  cycle type (000 classic, 010 incr burst, 111 end of burst)
- wb_bte_i  input  2  burst type (00 linear, 01 wrap4, 10 wrap8, 11 wrap16)
- wb_ack_o  output  1  acknowledge
- wb_err_o  output  1  error (out-of-range access)
- wb_rty_o  output  1  retry, tied 0
- wb_dat_o  output  DW  read data
- sram_ce  output  1  chip enable
- sram_we  output  1  write enable
- sram_oe  output  1  output enable
- sram_waddr  output  WORD_AW  word address
- sram_din  output  DW  write data
- sram_sel  output  SW  byte selects
- sram_dout  input  DW  read data, valid the cycle after a read address is issued

Behaviour:
- Word address: wadr = wb_adr_i[AW-1:log2(SW)].
- Range check: out-of-range when wadr >= MEM_SIZE_WORDS.
- Data paths: sram_din = wb_dat_i, sram_sel = wb_sel_i, wb_dat_o = sram_dout, all combinational.
- Registers: state {IDLE, RD_DATA}, addr_q[WORD_AW].
- Reset (rst=0): state=IDLE, addr_q=0. While in reset, wb_ack_o, wb_err_o, sram_ce and sram_we are forced to 0.
- IDLE, sram_waddr = wadr:
  - req = cyc&stb.
  - req & out-of-range: wb_err_o=1 in the same cycle, no SRAM access, stay IDLE.
  - req & we: sram_ce=sram_we=1, wb_ack_o=1 in the same cycle (combinational); stay IDLE. Write bursts therefore run 1 beat/cycle using the master-supplied address.
  - req & !we: sram_ce=sram_oe=1, addr_q<=wadr, ->RD_DATA. wb_ack_o=0 this cycle.
- RD_DATA, where sram_dout holds mem[addr_q]:
  - !cyc, or cyc&stb&we: ->IDLE, no ack, no SRAM access.
  - cyc&!stb (master wait): ack=0; re-read addr_q (sram_ce=oe=1, sram_waddr=addr_q); stay.
  - cyc&stb&!we: ack=1.
    - If wb_cti_i==010: sram_waddr=nxt (read issued), addr_q<=nxt, stay.
    - Otherwise (000, 111, or any reserved value): no SRAM access, ->IDLE.
- Next-address rule nxt(addr_q, bte):
  - linear: addr_q+1, modulo 2^WORD_AW.
  - wrapN: upper bits held, low log2(N) bits incremented modulo N.
  - If nxt >= MEM_SIZE_WORDS the read is still issued. The data is don't-care; the master must end the burst first.
- Latency:
  - Single read: 2 cycles from stb to ack.
  - N-beat read burst: N+1 cycles.
  - Write: 0 wait states.
- Exactly one of ack/err is asserted per beat; never both.

Decomposition:
- Shared package soc_wb_pkg holds:
  - CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_END=3'b111.
  - BTE_LINEAR/WRAP4/WRAP8/WRAP16.
  - The state enum typedef.
- Sub-module soc_wb2sram_nextaddr: purely combinational burst address computation (addr_q, bte -> nxt). Reusable by the dual-port bridge.

Test Plan:
- Single write: adr=0x10, dat=0xDEADBEEF, sel=4'b0011, classic -> same-cycle ack, sram_we=1, waddr=4, sel=0011. A later read of 0x10 returns 0x0000BEEF (preloaded mem=0).
- Single read: preload mem[8]=0x12345678, read adr=0x20 classic -> ack on the 2nd cycle, dat_o=0x12345678, sram idle on the ack cycle.
- Linear burst: 4-beat read from adr=0x40 (cti 010,010,010,111) -> acks on cycles 2..5 with data mem[16..19]; sram_waddr sequence 16,17,18,19.
- Wrap4 burst: bte=01, start adr=0x38 (word 14) -> data order mem[14],mem[15],mem[12],mem[13].
- Burst with wait: master drops stb for 2 cycles after beat 1 -> no ack during the wait, addr_q re-read each wait cycle, beat 2 data is correct after stb returns.
- Error and reset: MEM_SIZE_BYTE=1024, access at adr=0x400 -> err_o=1 the same cycle, no sram_ce. Assert rst=0 mid-burst -> ack=0 immediately, state IDLE; after release a fresh read behaves as a single read.

Source files
------------

// File: rtl/soc_wb_pkg.sv
// Shared Wishbone B3 definitions: cycle/burst type codes and bridge state type.
package soc_wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_DATA = 1'b1
    } wb2sram_state_e;

endpackage

// File: rtl/soc_wb2sram_if.sv
// Wishbone B3 slave-side signal bundle for the SRAM bridge.
interface soc_wb2sram_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    localparam int unsigned SW = DW / 8;

    logic [AW-1:0] wb_adr_i;
    logic [DW-1:0] wb_dat_i;
    logic [SW-1:0] wb_sel_i;
    logic          wb_we_i;
    logic          wb_cyc_i;
    logic          wb_stb_i;
    logic [2:0]    wb_cti_i;
    logic [1:0]    wb_bte_i;
    logic          wb_ack_o;
    logic          wb_err_o;
    logic          wb_rty_o;
    logic [DW-1:0] wb_dat_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
        input  wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
        output wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o
    );
endinterface

// File: rtl/soc_wb2sram_nextaddr.sv
// Burst next-word-address: linear increment or wrap within a 4/8/16-word window.
module soc_wb2sram_nextaddr
    import soc_wb_pkg::*;
#(
    parameter int unsigned WORD_AW = 30
) (
    input  logic [WORD_AW-1:0] addr,
    input  logic [1:0]         bte,
    output logic [WORD_AW-1:0] nxt
);

    logic [WORD_AW-1:0] inc;
    logic [WORD_AW-1:0] wrap_mask;

    // Bits under wrap_mask take the incremented value; the rest hold.
    always_comb begin
        inc       = addr + WORD_AW'(1);
        wrap_mask = '1;
        case (bte)
            BTE_WRAP4:  wrap_mask = WORD_AW'(3);
            BTE_WRAP8:  wrap_mask = WORD_AW'(7);
            BTE_WRAP16: wrap_mask = WORD_AW'(15);
            default:    wrap_mask = '1;
        endcase
        nxt = (addr & ~wrap_mask) | (inc & wrap_mask);
    end

endmodule

// File: rtl/soc_wb2sram.sv
// Wishbone B3 slave to single-port SRAM bridge: zero-wait writes, one-wait-state
// reads, and predictive address issue so read bursts stream at one beat per cycle.
module soc_wb2sram
    import soc_wb_pkg::*;
#(
    parameter int unsigned AW            = 32,
    parameter int unsigned DW            = 32,
    parameter int unsigned MEM_SIZE_BYTE = 1024,
    localparam int unsigned SW           = DW / 8,
    localparam int unsigned WORD_AW      = AW - (SW >> 1)
) (
    input  logic               clk,
    input  logic               rst,
    soc_wb2sram_if.slave       wb,
    output logic               sram_ce,
    output logic               sram_we,
    output logic               sram_oe,
    output logic [WORD_AW-1:0] sram_waddr,
    output logic [DW-1:0]      sram_din,
    output logic [SW-1:0]      sram_sel,
    input  logic [DW-1:0]      sram_dout
);

    localparam int unsigned MEM_SIZE_WORDS = MEM_SIZE_BYTE / SW;

    wb2sram_state_e     state, state_d;
    logic [WORD_AW-1:0] addr_q, addr_d;
    logic [WORD_AW-1:0] wadr;
    logic [WORD_AW-1:0] nxt;
    logic               req;
    logic               oor;
    logic               ack, err;
    logic               unused_adr_lsb;

    assign wadr           = wb.wb_adr_i[AW-1 -: WORD_AW];
    assign unused_adr_lsb = ^wb.wb_adr_i;
    assign req            = wb.wb_cyc_i & wb.wb_stb_i;
    assign oor            = wadr >= WORD_AW'(MEM_SIZE_WORDS);

    assign sram_din    = wb.wb_dat_i;
    assign sram_sel    = wb.wb_sel_i;
    assign wb.wb_dat_o = sram_dout;
    assign wb.wb_rty_o = 1'b0;
    assign wb.wb_ack_o = ack;
    assign wb.wb_err_o = err;

    soc_wb2sram_nextaddr #(
        .WORD_AW (WORD_AW)
    ) u_nextaddr (
        .addr (addr_q),
        .bte  (wb.wb_bte_i),
        .nxt  (nxt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            addr_q <= '0;
        end else begin
            state  <= state_d;
            addr_q <= addr_d;
        end
    end

    always_comb begin
        state_d    = state;
        addr_d     = addr_q;
        ack        = 1'b0;
        err        = 1'b0;
        sram_ce    = 1'b0;
        sram_we    = 1'b0;
        sram_oe    = 1'b0;
        sram_waddr = wadr;
        case (state)
            IDLE: begin
                if (req) begin
                    if (oor) begin
                        err = 1'b1;
                    end else if (wb.wb_we_i) begin
                        sram_ce = 1'b1;
                        sram_we = 1'b1;
                        ack     = 1'b1;
                    end else begin
                        sram_ce = 1'b1;
                        sram_oe = 1'b1;
                        addr_d  = wadr;
                        state_d = RD_DATA;
                    end
                end
            end
            RD_DATA: begin
                sram_waddr = addr_q;
                if (!wb.wb_cyc_i || (wb.wb_stb_i && wb.wb_we_i)) begin
                    state_d = IDLE;
                end else if (!wb.wb_stb_i) begin
                    // Master stall: keep re-reading so sram_dout stays valid.
                    sram_ce = 1'b1;
                    sram_oe = 1'b1;
                end else begin
                    ack = 1'b1;
                    if (wb.wb_cti_i == CTI_INCR) begin
                        sram_ce    = 1'b1;
                        sram_oe    = 1'b1;
                        sram_waddr = nxt;
                        addr_d     = nxt;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (!rst) begin
            ack     = 1'b0;
            err     = 1'b0;
            sram_ce = 1'b0;
            sram_we = 1'b0;
        end
    end

endmodule

// File: tb/tb_soc_wb2sram.sv
// Directed bench for soc_wb2sram with a behavioural single-port SRAM model.
module tb_soc_wb2sram;
    import soc_wb_pkg::*;

    localparam int unsigned AW      = 32;
    localparam int unsigned DW      = 32;
    localparam int unsigned SW      = DW / 8;
    localparam int unsigned WORD_AW = AW - (SW >> 1);
    localparam int unsigned MEMB    = 1024;
    localparam int unsigned NWORDS  = MEMB / SW;

    logic               clk = 1'b0;
    logic               rst;
    logic               mem_clr;
    logic               sram_ce, sram_we, sram_oe;
    logic [WORD_AW-1:0] sram_waddr;
    logic [DW-1:0]      sram_din, sram_dout;
    logic [SW-1:0]      sram_sel;
    logic [DW-1:0]      mem [NWORDS];

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    soc_wb2sram_if #(.AW(AW), .DW(DW)) wb ();

    soc_wb2sram #(
        .AW            (AW),
        .DW            (DW),
        .MEM_SIZE_BYTE (MEMB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wb         (wb),
        .sram_ce    (sram_ce),
        .sram_we    (sram_we),
        .sram_oe    (sram_oe),
        .sram_waddr (sram_waddr),
        .sram_din   (sram_din),
        .sram_sel   (sram_sel),
        .sram_dout  (sram_dout)
    );

    // Single-port SRAM: byte-lane writes, read data one cycle after the address.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < int'(NWORDS); i++) mem[i] <= '0;
        end else if (sram_ce) begin
            if (sram_we) begin
                if (sram_waddr < WORD_AW'(NWORDS))
                    for (int b = 0; b < int'(SW); b++)
                        if (sram_sel[b]) mem[sram_waddr[7:0]][8*b +: 8] <= sram_din[8*b +: 8];
            end else if (sram_oe) begin
                sram_dout <= (sram_waddr < WORD_AW'(NWORDS)) ? mem[sram_waddr[7:0]] : 'x;
            end
        end
    end

    function automatic logic [31:0] pat(input int k);
        return 32'hC0DE_0000 | 32'(k);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic c, input logic s, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] sl, input logic [2:0] ct,
                       input logic [1:0] bt);
        wb.wb_cyc_i = c;
        wb.wb_stb_i = s;
        wb.wb_we_i  = w;
        wb.wb_adr_i = a;
        wb.wb_dat_i = d;
        wb.wb_sel_i = sl;
        wb.wb_cti_i = ct;
        wb.wb_bte_i = bt;
    endtask

    task automatic nxt_cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, CTI_CLASSIC, BTE_LINEAR);
    endtask

    task automatic wr(input int word, input logic [31:0] d);
        nxt_cyc();
        bus(1'b1, 1'b1, 1'b1, 32'(word * 4), d, 4'hF, CTI_INCR, BTE_LINEAR);
        #3;
        chk("preload_ack", 64'(wb.wb_ack_o), 64'd1);
    endtask

    initial begin
        int order [4];
        rst     = 1'b0;
        mem_clr = 1'b1;
        idle();
        repeat (3) @(posedge clk);
        #1;
        mem_clr = 1'b0;

        // Request presented while reset is held: all strobes suppressed
        bus(1'b1, 1'b1, 1'b1, 32'h10, 32'h1, 4'hF, CTI_CLASSIC, BTE_LINEAR);
        #3;
        chk("rst_ack", 64'(wb.wb_ack_o), 64'd0);
        chk("rst_err", 64'(wb.wb_err_o), 64'd0);
        chk("rst_ce",  64'(sram_ce), 64'd0);
        chk("rst_we",  64'(sram_we), 64'd0);
        chk("rty",     64'(wb.wb_rty_o), 64'd0);
        nxt_cyc();
        idle();
        rst = 1'b1;

        // Single partial write
        nxt_cyc();
        bus(1'b1, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'b0011, CTI_CLASSIC, BTE_LINEAR);
        #3;
        chk("wr_ack",   64'(wb.wb_ack_o), 64'd1);
        chk("wr_err",   64'(wb.wb_err_o), 64'd0);
        chk("wr_ce",    64'(sram_ce), 64'd1);
        chk("wr_we",    64'(sram_we), 64'd1);
        chk("wr_waddr", 64'(sram_waddr), 64'd4);
        chk("wr_sel",   64'(sram_sel), 64'b0011);
        chk("wr_din",   64'(sram_din), 64'hDEADBEEF);
        nxt_cyc();
        idle();

        // Read back the partial write
        nxt_cyc();
        bus(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, CTI_CLASSIC, BTE_LINEAR);
        #3;
        chk("rb_ack0", 64'(wb.wb_ack_o), 64'd0);
        chk("rb_oe0",  64'(sram_oe), 64'd1);
        chk("rb_adr0", 64'(sram_waddr), 64'd4);
        nxt_cyc();
        #2;
        chk("rb_ack1", 64'(wb.wb_ack_o), 64'd1);
        chk("rb_dat",  64'(wb.wb_dat_o), 64'h0000BEEF);
        chk("rb_ce1",  64'(sram_ce), 64'd0);
        nxt_cyc();
        idle();

        // Preload via a back-to-back write burst
        wr(8, 32'h12345678);
        for (int k = 12; k < 20; k++) wr(k, pat(k));
        wr(255, 32'hFFFF0000);
        nxt_cyc();
        idle();

        // Single read of word 8
        nxt_cyc();
        bus(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF, CTI_CLASSIC, BTE_LINEAR);
        #3;
        chk("sr_ack0", 64'(wb.wb_ack_o), 64'd0);
        chk("sr_ce0",  64'(sram_ce), 64'd1);
        nxt_cyc();
        #2;
        chk("sr_ack1", 64'(wb.wb_ack_o), 64'd1);
        chk("sr_dat",  64'(wb.wb_dat_o), 64'h12345678);
        chk("sr_ce1",  64'(sram_ce), 64'd0);
        nxt_cyc();
        idle();

        // Linear 4-beat burst from word 16
        nxt_cyc();
        bus(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF, CTI_INCR, BTE_LINEAR);
        #3;
        chk("lin_ack0", 64'(wb.wb_ack_o), 64'd0);
        chk("lin_adr0", 64'(sram_waddr), 64'd16);
        for (int i = 0; i < 4; i++) begin
            nxt_cyc();
            bus(1'b1, 1'b1, 1'b0, 32'(32'h40 + 4 * i), 32'h0, 4'hF,
                (i == 3) ? CTI_END : CTI_INCR, BTE_LINEAR);
            #3;
            chk("lin_ack", 64'(wb.wb_ack_o), 64'd1);
            chk("lin_dat", 64'(wb.wb_dat_o), 64'(pat(16 + i)));
            if (i < 3) chk("lin_adr", 64'(sram_waddr), 64'(17 + i));
            else       chk("lin_ce_end", 64'(sram_ce), 64'd0);
        end
        nxt_cyc();
        idle();

        // Wrap4 burst from word 14
        order[0] = 14; order[1] = 15; order[2] = 12; order[3] = 13;
        nxt_cyc();
        bus(1'b1, 1'b1, 1'b0, 32'h38, 32'h0, 4'hF, CTI_INCR, BTE_WRAP4);
        #3;
        chk("wr4_adr0", 64'(sram_waddr), 64'd14);
        for (int i = 0; i < 4; i++) begin
            nxt_cyc();
            bus(1'b1, 1'b1, 1'b0, 32'(order[i] * 4), 32'h0, 4'hF,
                (i == 3) ? CTI_END : CTI_INCR, BTE_WRAP4);
            #3;
            chk("wr4_ack", 64'(wb.wb_ack_o), 64'd1);
            chk("wr4_dat", 64'(wb.wb_dat_o), 64'(pat(order[i])));
            if (i < 3) chk("wr4_adr", 64'(sram_waddr), 64'(order[i + 1]));
        end
        nxt_cyc();
        idle();

        // Burst with a two-cycle master stall after beat 1
        nxt_cyc();
        bus(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF, CTI_INCR, BTE_LINEAR);
        nxt_cyc();
        #2;
        chk("wt_ack1", 64'(wb.wb_ack_o), 64'd1);
        chk("wt_dat1", 64'(wb.wb_dat_o), 64'(pat(16)));
        for (int i = 0; i < 2; i++) begin
            nxt_cyc();
            bus(1'b1, 1'b0, 1'b0, 32'h44, 32'h0, 4'hF, CTI_INCR, BTE_LINEAR);
            #3;
            chk("wt_stall_ack", 64'(wb.wb_ack_o), 64'd0);
            chk("wt_stall_ce",  64'(sram_ce), 64'd1);
            chk("wt_stall_adr", 64'(sram_waddr), 64'd17);
        end
        nxt_cyc();
        bus(1'b1, 1'b1, 1'b0, 32'h44, 32'h0, 4'hF, CTI_END, BTE_LINEAR);
        #3;
        chk("wt_ack2", 64'(wb.wb_ack_o), 64'd1);
        chk("wt_dat2", 64'(wb.wb_dat_o), 64'(pat(17)));
        nxt_cyc();
        idle();

        // Range boundary: last word readable, first word past the end errors
        nxt_cyc();
        bus(1'b1, 1'b1, 1'b0, 32'h3FC, 32'h0, 4'hF, CTI_CLASSIC, BTE_LINEAR);
        #3;
        chk("last_err", 64'(wb.wb_err_o), 64'd0);
        nxt_cyc();
        #2;
        chk("last_dat", 64'(wb.wb_dat_o), 64'hFFFF0000);
        nxt_cyc();
        idle();
        nxt_cyc();
        bus(1'b1, 1'b1, 1'b0, 32'h400, 32'h0, 4'hF, CTI_CLASSIC, BTE_LINEAR);
        #3;
        chk("oor_rd_err", 64'(wb.wb_err_o), 64'd1);
        chk("oor_rd_ack", 64'(wb.wb_ack_o), 64'd0);
        chk("oor_rd_ce",  64'(sram_ce), 64'd0);
        nxt_cyc();
        bus(1'b1, 1'b1, 1'b1, 32'h400, 32'h5, 4'hF, CTI_CLASSIC, BTE_LINEAR);
        #3;
        chk("oor_wr_err", 64'(wb.wb_err_o), 64'd1);
        chk("oor_wr_ack", 64'(wb.wb_ack_o), 64'd0);
        chk("oor_wr_we",  64'(sram_we), 64'd0);
        nxt_cyc();
        idle();

        // Reset asserted mid-burst
        nxt_cyc();
        bus(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF, CTI_INCR, BTE_LINEAR);
        nxt_cyc();
        #2;
        chk("mrst_beat1", 64'(wb.wb_ack_o), 64'd1);
        nxt_cyc();
        rst = 1'b0;
        #2;
        chk("mrst_ack", 64'(wb.wb_ack_o), 64'd0);
        chk("mrst_ce",  64'(sram_ce), 64'd0);
        nxt_cyc();
        idle();
        rst = 1'b1;
        nxt_cyc();
        bus(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF, CTI_CLASSIC, BTE_LINEAR);
        #3;
        chk("post_ack0", 64'(wb.wb_ack_o), 64'd0);
        chk("post_ce0",  64'(sram_ce), 64'd1);
        chk("post_adr0", 64'(sram_waddr), 64'd8);
        nxt_cyc();
        #2;
        chk("post_ack1", 64'(wb.wb_ack_o), 64'd1);
        chk("post_dat",  64'(wb.wb_dat_o), 64'h12345678);
        nxt_cyc();
        idle();
        nxt_cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
